proc_core: RTL and testbench
============================

# proc_core

Parametrised multi-cycle processor core, successor to the single-cycle 16-bit debug processor. Executes one 16-bit instruction per `step` request through a fetch/execute/writeback state machine, drives the instruction-memory address, and publishes OUT results with a valid strobe. Adds a configurable data width and program depth, a full ALU, branches/jumps, halt, and an explicit busy handshake in place of the hard-coded clock divider.

## Interface
- `DATA_W`, 16: register/ALU/result width; legal range 8..32.
- `IMEM_DEPTH`, 8: program length in instructions; power of two, 2..256. `PC_W` = log2(`IMEM_DEPTH`).
- `REG_COUNT`, 8: general registers; one of 2, 4, 8. Register fields use their low log2(`REG_COUNT`) bits.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `step`  in  1  request to execute the instruction at `address`; sampled only in IDLE.
- `instruction`  in  16  instruction word for `address`; must be stable in the cycle `step` is accepted.
- `address`  out  PC_W  program counter / instruction-memory address.
- `result`  out  DATA_W  last value written by OUT.
- `result_valid`  out  1  one-cycle pulse when `result` is updated.
- `busy`  out  1  high whenever state is not IDLE (including HALT).
- `halted`  out  1  high in HALT.

## Operation
- Format: opcode[15:12], ra[11:9], rb[8:6], imm[7:0].
- Opcodes: 0x0 NOP; 0x1 LDI ra←zero-ext imm; 0x2 ADD ra←ra+rb; 0x3 SUB ra←ra−rb; 0x4 AND; 0x5 OR; 0x6 XOR; 0x7 SHL ra←ra<<1; 0x8 BEQ if ra==rb then pc←imm[PC_W-1:0]; 0x9 JMP pc←imm[PC_W-1:0]; 0xE HALT; 0xF OUT result←ra; others NOP.
- Arithmetic modulo 2^DATA_W; no flags, no carry out. Imm bits above PC_W ignored for branches.
- Register file: REG_COUNT × DATA_W, two combinational read ports (ra, rb), one synchronous write port (ra). All registers writable, including r0.
- Non-branching instructions: pc←pc+1, wrapping IMEM_DEPTH−1→0. Taken BEQ/JMP override the increment; untaken BEQ increments.
- States: IDLE → (step) EXEC → WB → IDLE; WB on HALT opcode → HALT; HALT exits only on reset.
- IDLE: on `step`=1 latch `instruction` into IR, go EXEC.
- EXEC: read ra/rb from IR fields, register ALU result and branch decision.
- WB: write ra (LDI, ALU ops), update pc, load `result` and pulse `result_valid` (OUT).
- `step` outside IDLE is ignored and not queued.
- Reset (any state, any time): state IDLE, pc 0, all registers 0, `result` 0, `result_valid` 0, `busy` 0, `halted` 0; in-flight instruction discarded with no write.

## Timing
- `step` sampled high at edge N (state IDLE): EXEC after N, WB after N+1, register write/pc/result visible after edge N+2, IDLE again after N+2.
- `busy` high from after N through to edge N+2; next `step` acceptable at edge N+3. Max throughput: one instruction per 3 cycles.
- `result_valid` high exactly one cycle, after edge N+2, for OUT only.
- `address` changes only at WB edge; `instruction` for the new `address` must be valid before the next accepted `step` (combinational ROM lookup meets this).
- Back-to-back dependent instructions need no forwarding: WB completes before the next IR latch.
- `halted`/`busy` assert after the WB edge of HALT; `address` holds the HALT location (no increment).

## Test plan
- Reset mid-EXEC of ADD: assert `rst_n`=0 → all outputs 0 immediately (asynchronous), target register stays 0, `address`=0.
- Program LDI r1,5; LDI r2,7; ADD r1,r2; OUT r1 with step held high → `result`=12 with one `result_valid` pulse 12 cycles after first step, `address`=4.
- DATA_W=8: LDI r1,0xFF; LDI r2,0x02; ADD r1,r2; OUT r1 → `result`=0x01 (wrap). SUB 0−1 → 0xFF.
- IMEM_DEPTH=8, eight NOPs stepped nine times → `address` sequence 1..7,0,1.
- BEQ r0,r0,imm=0x05 → `address`=5; BEQ with r1=1,r2=2 → `address`=pc+1; JMP imm=0xFD with IMEM_DEPTH=8 → `address`=5.
- HALT followed by further `step` pulses → `halted`=1, `busy`=1, `address` frozen, no `result_valid`; `rst_n` pulse restores IDLE.

Source files
------------

// File: rtl/proc_core.sv
// ============================================================================
// Module      : proc_core
// Description : Multi-cycle 16-bit-instruction processor core; one instruction
//               per accepted step through IDLE -> EXEC -> WB.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module proc_core #(
    parameter int DATA_W     = 16,
    parameter int IMEM_DEPTH = 8,
    parameter int REG_COUNT  = 8,
    localparam int PC_W      = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic [15:0]       instruction,
    output logic [PC_W-1:0]   address,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              busy,
    output logic              halted
);

    localparam int RW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    localparam logic [3:0] c_OP_LDI  = 4'h1;
    localparam logic [3:0] c_OP_ADD  = 4'h2;
    localparam logic [3:0] c_OP_SUB  = 4'h3;
    localparam logic [3:0] c_OP_AND  = 4'h4;
    localparam logic [3:0] c_OP_OR   = 4'h5;
    localparam logic [3:0] c_OP_XOR  = 4'h6;
    localparam logic [3:0] c_OP_SHL  = 4'h7;
    localparam logic [3:0] c_OP_BEQ  = 4'h8;
    localparam logic [3:0] c_OP_JMP  = 4'h9;
    localparam logic [3:0] c_OP_HALT = 4'hE;
    localparam logic [3:0] c_OP_OUT  = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [15:0]         r_ir;
    logic [PC_W-1:0]     r_pc;
    logic [DATA_W-1:0]   r_regs [REG_COUNT];
    logic [DATA_W-1:0]   r_alu;
    logic                r_take;
    logic [DATA_W-1:0]   r_result;
    logic                r_result_valid;

    logic [3:0]          w_op;
    logic [RW-1:0]       w_ra_idx;
    logic [RW-1:0]       w_rb_idx;
    logic [DATA_W-1:0]   w_ra_val;
    logic [DATA_W-1:0]   w_rb_val;
    logic [DATA_W-1:0]   w_alu;
    logic                w_writes;
    logic [PC_W-1:0]     w_target;

    assign w_op     = r_ir[15:12];
    assign w_ra_idx = r_ir[9 +: RW];
    assign w_rb_idx = r_ir[6 +: RW];
    assign w_ra_val = r_regs[w_ra_idx];
    assign w_rb_val = r_regs[w_rb_idx];
    assign w_target = r_ir[PC_W-1:0];
    assign w_writes = (w_op >= c_OP_LDI) && (w_op <= c_OP_SHL);

    // OUT passes ra through the ALU so WB loads result from one register.
    always_comb begin
        w_alu = '0;
        case (w_op)
            c_OP_LDI: w_alu = DATA_W'(r_ir[7:0]);
            c_OP_ADD: w_alu = w_ra_val + w_rb_val;
            c_OP_SUB: w_alu = w_ra_val - w_rb_val;
            c_OP_AND: w_alu = w_ra_val & w_rb_val;
            c_OP_OR:  w_alu = w_ra_val | w_rb_val;
            c_OP_XOR: w_alu = w_ra_val ^ w_rb_val;
            c_OP_SHL: w_alu = w_ra_val << 1;
            c_OP_OUT: w_alu = w_ra_val;
            default:  w_alu = '0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (step) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_WB;
            S_WB:    w_next_state = (w_op == c_OP_HALT) ? S_HALT : S_IDLE;
            S_HALT:  w_next_state = S_HALT;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_ir           <= '0;
            r_pc           <= '0;
            r_alu          <= '0;
            r_take         <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
        end else begin
            r_state        <= w_next_state;
            r_result_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (step) r_ir <= instruction;
                S_EXEC: begin
                    r_alu  <= w_alu;
                    r_take <= (w_op == c_OP_JMP) ||
                              ((w_op == c_OP_BEQ) && (w_ra_val == w_rb_val));
                end
                S_WB: begin
                    if (w_writes) r_regs[w_ra_idx] <= r_alu;
                    if (w_op == c_OP_OUT) begin
                        r_result       <= r_alu;
                        r_result_valid <= 1'b1;
                    end
                    // HALT keeps pc on its own location.
                    if (w_op != c_OP_HALT)
                        r_pc <= r_take ? w_target : r_pc + PC_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign address      = r_pc;
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign busy         = (r_state != S_IDLE);
    assign halted       = (r_state == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_proc_core.sv
// ============================================================================
// Module      : tb_proc_core
// Description : Directed self-checking bench for proc_core (DATA_W=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_proc_core;

    logic        clk;
    logic        rst_n;
    logic        step;
    logic [15:0] instruction;
    logic [2:0]  address;
    logic [7:0]  result;
    logic        result_valid;
    logic        busy;
    logic        halted;

    logic [15:0] rom [8];
    int          n_total;
    int          n_pass;
    int          pulses;

    proc_core #(
        .DATA_W    (8),
        .IMEM_DEPTH(8),
        .REG_COUNT (8)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .step        (step),
        .instruction (instruction),
        .address     (address),
        .result      (result),
        .result_valid(result_valid),
        .busy        (busy),
        .halted      (halted)
    );

    assign instruction = rom[address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Starts and ends on a falling edge with the core back in IDLE.
    task automatic run_step(output int n_pulse);
        n_pulse = 0;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (result_valid) n_pulse++;
        end
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        step    = 1'b0;
        for (int i = 0; i < 8; i++) rom[i] = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_address", address, 0);
        check("rst_result", result, 0);
        check("rst_valid", result_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);

        // LDI r1,5; LDI r2,7; ADD r1,r2; OUT r1 with step held high
        rom[0] = 16'h1205; rom[1] = 16'h1407; rom[2] = 16'h2280; rom[3] = 16'hF200;
        pulses = 0;
        step = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (result_valid) pulses++;
        end
        step = 1'b0;
        check("add_valid_at_12", result_valid, 1);
        check("add_result", result, 8'd12);
        check("add_address", address, 4);
        check("add_pulses", pulses, 1);
        @(negedge clk);
        check("add_valid_drop", result_valid, 0);

        // 8-bit wraparound on ADD and SUB, then through address 7 -> 0
        do_reset();
        rom[0] = 16'h12FF; rom[1] = 16'h1402; rom[2] = 16'h2280; rom[3] = 16'hF200;
        rom[4] = 16'h1601; rom[5] = 16'h38C0; rom[6] = 16'hF800; rom[7] = 16'h0000;
        for (int k = 0; k < 4; k++) run_step(pulses);
        check("wrap_add_pulse", pulses, 1);
        check("wrap_add", result, 8'h01);
        for (int k = 0; k < 3; k++) run_step(pulses);
        check("wrap_sub", result, 8'hFF);
        run_step(pulses);
        check("wrap_addr0", address, 0);

        // Logic ops and shift
        do_reset();
        rom[0] = 16'h12CA; rom[1] = 16'h145C; rom[2] = 16'h6280; rom[3] = 16'hF200;
        rom[4] = 16'h4440; rom[5] = 16'hF400; rom[6] = 16'h7200; rom[7] = 16'hF200;
        for (int k = 0; k < 4; k++) run_step(pulses);
        check("xor", result, 8'h96);
        for (int k = 0; k < 2; k++) run_step(pulses);
        check("and", result, 8'h14);
        for (int k = 0; k < 2; k++) run_step(pulses);
        check("shl", result, 8'h2C);

        // Eight NOPs stepped nine times
        do_reset();
        for (int i = 0; i < 8; i++) rom[i] = 16'h0000;
        for (int k = 1; k <= 9; k++) begin
            run_step(pulses);
            check($sformatf("nop_addr_%0d", k), address, k % 8);
            check($sformatf("nop_novalid_%0d", k), pulses, 0);
        end

        // Branches: taken BEQ, untaken BEQ with wrap, JMP with high imm bits
        do_reset();
        rom[0] = 16'h8005; rom[5] = 16'h1201; rom[6] = 16'h1402; rom[7] = 16'h8283;
        run_step(pulses);
        check("beq_taken", address, 5);
        run_step(pulses);
        run_step(pulses);
        run_step(pulses);
        check("beq_untaken", address, 0);
        rom[0] = 16'h90FD;
        run_step(pulses);
        check("jmp_fd", address, 5);

        // HALT and ignored steps
        rom[5] = 16'hE000;
        run_step(pulses);
        check("halt_halted", halted, 1);
        check("halt_busy", busy, 1);
        check("halt_addr", address, 5);
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            int p;
            run_step(p);
            pulses += p;
        end
        check("halt_frozen", address, 5);
        check("halt_still", halted, 1);
        check("halt_novalid", pulses, 0);
        do_reset();
        check("halt_rst_halted", halted, 0);
        check("halt_rst_busy", busy, 0);
        check("halt_rst_addr", address, 0);

        // Reset during EXEC of ADD discards the write
        rom[0] = 16'h1404; rom[1] = 16'h2280;
        run_step(pulses);
        rom[0] = 16'hF200;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        check("mid_busy_exec", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_addr", address, 0);
        check("mid_rst_valid", result_valid, 0);
        check("mid_rst_result", result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_step(pulses);
        check("mid_out_pulse", pulses, 1);
        check("mid_r1_zero", result, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
